// File: rtl/tva_prec_pkg.sv
// Shared definitions for the token quantizer: precision classes, FSM states,
// rounding/saturation constants and small decode helpers.
package tva_prec_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned QUANT_WIDTH = 17;

  typedef enum logic [1:0] {
    PREC_INT4 = 2'd0,
    PREC_INT8 = 2'd1,
    PREC_FP16 = 2'd2
  } prec_code_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Round-half-up offsets, arithmetic shifts and saturation bounds.
  localparam logic signed [QUANT_WIDTH-1:0] INT8_RND   = 17'sd128;
  localparam int unsigned                   INT8_SHIFT = 8;
  localparam logic signed [QUANT_WIDTH-1:0] INT8_MAX   = 17'sd127;
  localparam logic signed [QUANT_WIDTH-1:0] INT8_MIN   = -17'sd128;
  localparam logic signed [QUANT_WIDTH-1:0] INT4_RND   = 17'sd2048;
  localparam int unsigned                   INT4_SHIFT = 12;
  localparam logic signed [QUANT_WIDTH-1:0] INT4_MAX   = 17'sd7;
  localparam logic signed [QUANT_WIDTH-1:0] INT4_MIN   = -17'sd8;

  // Codes 2..15 all fall back to 16-bit passthrough.
  function automatic prec_code_t decode_code(input logic [3:0] code);
    case (code)
      4'd0:    decode_code = PREC_INT4;
      4'd1:    decode_code = PREC_INT8;
      default: decode_code = PREC_FP16;
    endcase
  endfunction

  function automatic int unsigned words_per_token(input prec_code_t p, input int unsigned d);
    case (p)
      PREC_INT4: words_per_token = d / 4;
      PREC_INT8: words_per_token = d / 2;
      default:   words_per_token = d;
    endcase
  endfunction

endpackage

// File: rtl/token_quantizer_if.sv
// Token-vector input stream and packed-word output stream of the quantizer.
//   tok_valid/tok_ready/tok_data : one D-element signed token vector per handshake
//   out_valid/out_ready/out_data : packed 16-bit words, with out_prec class and out_last
// master = quantizer side, slave = producer/consumer side.
interface token_quantizer_if
  import tva_prec_pkg::*;
#(
  parameter int unsigned D = 8
) ();

  logic                    tok_valid;
  logic                    tok_ready;
  logic [DATA_WIDTH*D-1:0] tok_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [1:0]              out_prec;
  logic                    out_last;

  modport master (
    input  tok_valid, tok_data, out_ready,
    output tok_ready, out_valid, out_data, out_prec, out_last
  );

  modport slave (
    output tok_valid, tok_data, out_ready,
    input  tok_ready, out_valid, out_data, out_prec, out_last
  );

endinterface

// File: rtl/tok_elem_quant.sv
// Combinational quantizer for one signed 16-bit element.
//   elem_i  : signed input element
//   prec_i  : target precision class
//   quant_c : quantized value, right-aligned and sign-extended to 16 bits
module tok_elem_quant
  import tva_prec_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] elem_i,
  input  prec_code_t            prec_i,
  output logic [DATA_WIDTH-1:0] quant_c
);

  logic signed [QUANT_WIDTH-1:0] x_ext;
  logic signed [QUANT_WIDTH-1:0] q8;
  logic signed [QUANT_WIDTH-1:0] q4;
  logic signed [QUANT_WIDTH-1:0] sat8;
  logic signed [QUANT_WIDTH-1:0] sat4;

  // 17-bit arithmetic keeps x + offset from overflowing before the shift.
  always_comb begin
    x_ext   = QUANT_WIDTH'(signed'(elem_i));
    q8      = (x_ext + INT8_RND) >>> INT8_SHIFT;
    q4      = (x_ext + INT4_RND) >>> INT4_SHIFT;
    sat8    = (q8 > INT8_MAX) ? INT8_MAX : ((q8 < INT8_MIN) ? INT8_MIN : q8);
    sat4    = (q4 > INT4_MAX) ? INT4_MAX : ((q4 < INT4_MIN) ? INT4_MIN : q4);
    quant_c = elem_i;
    case (prec_i)
      PREC_INT8: quant_c = DATA_WIDTH'(sat8);
      PREC_INT4: quant_c = DATA_WIDTH'(sat4);
      default:   quant_c = elem_i;
    endcase
  end

endmodule

// File: rtl/token_quantizer.sv
// Per-token mixed-precision quantizer and word packer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a run of L tokens (sampled in S_IDLE only)
//   done            : one-cycle pulse after the last word of token L-1
//   token_precision : 4-bit code per token, latched on start
//   tq (master)     : token input stream and packed-word output stream
// Optional (TOKQ_STATS_EN): stat_int4/stat_int8/stat_fp16 per-class token counts.
module token_quantizer
  import tva_prec_pkg::*;
#(
  parameter int unsigned L = 8,
  parameter int unsigned D = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  input  logic [4*L-1:0]   token_precision,
  token_quantizer_if.master tq
`ifdef TOKQ_STATS_EN
  ,
  output logic [$clog2(L+1)-1:0] stat_int4,
  output logic [$clog2(L+1)-1:0] stat_int8,
  output logic [$clog2(L+1)-1:0] stat_fp16
`endif
);

  localparam int unsigned TW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned WW = $clog2(D);
  localparam int unsigned BW = DATA_WIDTH * D;

  state_t                state_q, state_d;
  logic [TW-1:0]         tok_idx_q, tok_idx_d;
  logic [WW-1:0]         word_idx_q, word_idx_d;
  logic [4*L-1:0]        codes_q, codes_d;
  logic [BW-1:0]         data_q, data_d;
  prec_code_t            prec_q, prec_d;
  logic                  done_q, done_d;
  logic                  tok_ready_q, tok_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            out_prec_q, out_prec_d;
  logic                  out_last_q, out_last_d;

  logic                  accept_c;
  logic [DATA_WIDTH-1:0] q_elem [D];
  logic [BW-1:0]         q4_flat, q8_flat, q16_flat;
  logic [DATA_WIDTH-1:0] word_sel_c;

`ifdef TOKQ_STATS_EN
  localparam int unsigned SW = $clog2(L + 1);
  logic [SW-1:0] st4_q, st4_d, st8_q, st8_d, st16_q, st16_d;
`endif

  assign accept_c = out_valid_q && tq.out_ready;

  // Quantizers see the next-cycle token so the first word registers right after the handshake.
  for (genvar k = 0; k < D; k++) begin : g_quant
    tok_elem_quant u_quant (
      .elem_i  (data_d[DATA_WIDTH*k +: DATA_WIDTH]),
      .prec_i  (prec_d),
      .quant_c (q_elem[k])
    );
  end

  // Next-state and run bookkeeping.
  always_comb begin
    state_d    = state_q;
    tok_idx_d  = tok_idx_q;
    word_idx_d = word_idx_q;
    codes_d    = codes_q;
    data_d     = data_q;
    prec_d     = prec_q;
`ifdef TOKQ_STATS_EN
    st4_d      = st4_q;
    st8_d      = st8_q;
    st16_d     = st16_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          codes_d   = token_precision;
          tok_idx_d = '0;
          state_d   = S_LOAD;
`ifdef TOKQ_STATS_EN
          st4_d     = '0;
          st8_d     = '0;
          st16_d    = '0;
`endif
        end
      end
      S_LOAD: begin
        if (tq.tok_valid && tok_ready_q) begin
          data_d     = tq.tok_data;
          prec_d     = decode_code(codes_q[{tok_idx_q, 2'b00} +: 4]);
          word_idx_d = '0;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (accept_c) begin
          if (out_last_q) begin
            word_idx_d = '0;
            if (tok_idx_q == TW'(L - 1)) begin
              state_d = S_DONE;
            end else begin
              tok_idx_d = tok_idx_q + TW'(1);
              state_d   = S_LOAD;
            end
`ifdef TOKQ_STATS_EN
            case (prec_q)
              PREC_INT4: if (st4_q != SW'(L)) st4_d = st4_q + SW'(1);
              PREC_INT8: if (st8_q != SW'(L)) st8_d = st8_q + SW'(1);
              default:   if (st16_q != SW'(L)) st16_d = st16_q + SW'(1);
            endcase
`endif
          end else begin
            word_idx_d = word_idx_q + WW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; a stalled word recomputes identically.
  always_comb begin
    q4_flat  = '0;
    q8_flat  = '0;
    q16_flat = '0;
    for (int k = 0; k < D; k++) begin
      q4_flat[4*k +: 4]                    = q_elem[k][3:0];
      q8_flat[8*k +: 8]                    = q_elem[k][7:0];
      q16_flat[DATA_WIDTH*k +: DATA_WIDTH] = q_elem[k];
    end
    case (prec_d)
      PREC_INT4: word_sel_c = q4_flat[{word_idx_d, 4'b0000} +: DATA_WIDTH];
      PREC_INT8: word_sel_c = q8_flat[{word_idx_d, 4'b0000} +: DATA_WIDTH];
      default:   word_sel_c = q16_flat[{word_idx_d, 4'b0000} +: DATA_WIDTH];
    endcase
    tok_ready_d = (state_d == S_LOAD);
    out_valid_d = (state_d == S_EMIT);
    done_d      = (state_d == S_DONE);
    out_data_d  = '0;
    out_prec_d  = '0;
    out_last_d  = 1'b0;
    if (state_d == S_EMIT) begin
      out_data_d = word_sel_c;
      out_prec_d = prec_d;
      out_last_d = (word_idx_d == WW'(words_per_token(prec_d, D) - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tok_idx_q   <= '0;
      word_idx_q  <= '0;
      codes_q     <= '0;
      data_q      <= '0;
      prec_q      <= PREC_INT4;
      done_q      <= 1'b0;
      tok_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_prec_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef TOKQ_STATS_EN
      st4_q       <= '0;
      st8_q       <= '0;
      st16_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tok_idx_q   <= tok_idx_d;
      word_idx_q  <= word_idx_d;
      codes_q     <= codes_d;
      data_q      <= data_d;
      prec_q      <= prec_d;
      done_q      <= done_d;
      tok_ready_q <= tok_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_prec_q  <= out_prec_d;
      out_last_q  <= out_last_d;
`ifdef TOKQ_STATS_EN
      st4_q       <= st4_d;
      st8_q       <= st8_d;
      st16_q      <= st16_d;
`endif
    end
  end

  assign done         = done_q;
  assign tq.tok_ready = tok_ready_q;
  assign tq.out_valid = out_valid_q;
  assign tq.out_data  = out_data_q;
  assign tq.out_prec  = out_prec_q;
  assign tq.out_last  = out_last_q;
`ifdef TOKQ_STATS_EN
  assign stat_int4    = st4_q;
  assign stat_int8    = st8_q;
  assign stat_fp16    = st16_q;
`endif

endmodule

// File: tb/tb_token_quantizer.sv
// Directed bench for token_quantizer: dut_a (L=1, D=4) and dut_b (L=3, D=8)
// share stimulus; sel picks which one receives start/tok_valid and is observed.
module tb_token_quantizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel;
  logic         start;
  logic [11:0]  prec_vec;
  logic         tok_valid;
  logic [127:0] tok_data;
  logic         out_ready;
  logic         a_done, b_done;

  always #5 clk = ~clk;

  token_quantizer_if #(.D(4)) if_a ();
  token_quantizer_if #(.D(8)) if_b ();

  assign if_a.tok_valid = tok_valid & ~sel;
  assign if_a.tok_data  = tok_data[63:0];
  assign if_a.out_ready = out_ready;
  assign if_b.tok_valid = tok_valid & sel;
  assign if_b.tok_data  = tok_data;
  assign if_b.out_ready = out_ready;

`ifdef TOKQ_STATS_EN
  logic [0:0] a_s4, a_s8, a_s16;
  logic [1:0] b_s4, b_s8, b_s16;
`endif

  token_quantizer #(.L(1), .D(4)) dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start & ~sel),
    .done            (a_done),
    .token_precision (prec_vec[3:0]),
    .tq              (if_a)
`ifdef TOKQ_STATS_EN
    ,
    .stat_int4       (a_s4),
    .stat_int8       (a_s8),
    .stat_fp16       (a_s16)
`endif
  );

  token_quantizer #(.L(3), .D(8)) dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start & sel),
    .done            (b_done),
    .token_precision (prec_vec),
    .tq              (if_b)
`ifdef TOKQ_STATS_EN
    ,
    .stat_int4       (b_s4),
    .stat_int8       (b_s8),
    .stat_fp16       (b_s16)
`endif
  );

  logic        o_done, o_tok_ready, o_valid, o_last;
  logic [15:0] o_data;
  logic [1:0]  o_prec;
  assign o_done      = sel ? b_done         : a_done;
  assign o_tok_ready = sel ? if_b.tok_ready : if_a.tok_ready;
  assign o_valid     = sel ? if_b.out_valid : if_a.out_valid;
  assign o_data      = sel ? if_b.out_data  : if_a.out_data;
  assign o_prec      = sel ? if_b.out_prec  : if_a.out_prec;
  assign o_last      = sel ? if_b.out_last  : if_a.out_last;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0]  cap_data[$];
  logic [1:0]   cap_prec[$];
  logic         cap_last[$];
  int           cap_wpt[$];
  int           cap_done, stall_viol, rdy_viol, lat_viol;
  bit           feed_timeout;
  logic [127:0] vec [3];

  // Presents tokens vec[0..n-1], waiting gap cycles after tok_ready before each.
  task automatic feed(input int n, input int gap, input bit mid_start);
    for (int t = 0; t < n; t++) begin
      int w;
      w = 0;
      while (!o_tok_ready && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      if (!o_tok_ready) begin
        feed_timeout = 1'b1;
        break;
      end
      repeat (gap) begin
        @(posedge clk); #1;
      end
      tok_data  = vec[t];
      tok_valid = 1'b1;
      @(posedge clk); #1;
      tok_valid = 1'b0;
      if (!o_valid) lat_viol++;
      if (mid_start && t == 1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  // Accepts words under a 4-phase out_ready pattern until a few cycles past done.
  task automatic collect(input int max_cyc, input logic [3:0] pat);
    int          cur;
    int          tail;
    bit          stalled;
    logic [18:0] held;
    cap_data.delete(); cap_prec.delete(); cap_last.delete(); cap_wpt.delete();
    cap_done = 0; stall_viol = 0; rdy_viol = 0;
    cur = 0; tail = -1; stalled = 1'b0; held = '0;
    for (int c = 0; c < max_cyc; c++) begin
      logic [1:0] ph;
      ph = 2'(c);
      out_ready = pat[ph];
      if (stalled && (!o_valid || {o_prec, o_last, o_data} !== held)) stall_viol++;
      stalled = 1'b0;
      if (o_valid) begin
        if (o_tok_ready) rdy_viol++;
        if (out_ready) begin
          cap_data.push_back(o_data);
          cap_prec.push_back(o_prec);
          cap_last.push_back(o_last);
          cur++;
          if (o_last) begin
            cap_wpt.push_back(cur);
            cur = 0;
          end
        end else begin
          stalled = 1'b1;
          held    = {o_prec, o_last, o_data};
        end
      end
      if (o_done) cap_done++;
      if (cap_done > 0 && tail < 0) tail = 3;
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [11:0] codes, input int n, input int gap,
                     input bit mid_start, input logic [3:0] pat);
    prec_vec = codes;
    lat_viol = 0;
    feed_timeout = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      feed(n, gap, mid_start);
      collect(400, pat);
    join
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({a_done, if_a.tok_ready, if_a.out_valid, if_a.out_prec, if_a.out_last, if_a.out_data} !== 22'h0)
      $display("FAIL reset_a: got %h want 0", {a_done, if_a.tok_ready, if_a.out_valid, if_a.out_prec, if_a.out_last, if_a.out_data});
    else pass_cnt++;
    total_cnt++;
    if ({b_done, if_b.tok_ready, if_b.out_valid, if_b.out_prec, if_b.out_last, if_b.out_data} !== 22'h0)
      $display("FAIL reset_b: got %h want 0", {b_done, if_b.tok_ready, if_b.out_valid, if_b.out_prec, if_b.out_last, if_b.out_data});
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({o_tok_ready, o_valid, o_done} !== 3'b000)
      $display("FAIL idle_after_reset: got %b want 000", {o_tok_ready, o_valid, o_done});
    else pass_cnt++;
  endtask

  task automatic test_int4();
    sel = 1'b0;
    vec[0] = {64'h0, 16'h0000, 16'h8000, 16'h7FF0, 16'h1234};
    run(12'h000, 1, 0, 1'b0, 4'hF);
    total_cnt++;
    if (cap_data.size() !== 1) $display("FAIL int4_count: got %0d want 1", cap_data.size());
    else pass_cnt++;
    total_cnt++;
    if (cap_data[0] !== 16'h0871) $display("FAIL int4_word: got %h want 0871", cap_data[0]);
    else pass_cnt++;
    total_cnt++;
    if ({cap_prec[0], cap_last[0]} !== 3'b001) $display("FAIL int4_prec_last: got %b want 001", {cap_prec[0], cap_last[0]});
    else pass_cnt++;
    total_cnt++;
    if (cap_done !== 1 || lat_viol !== 0 || feed_timeout)
      $display("FAIL int4_done: done %0d lat %0d to %0d want 1 0 0", cap_done, lat_viol, feed_timeout);
    else pass_cnt++;
  endtask

  task automatic test_int8();
    sel = 1'b0;
    vec[0] = {64'h0, 16'h0000, 16'h8000, 16'h7FF0, 16'h1234};
    run(12'h001, 1, 0, 1'b0, 4'hF);
    total_cnt++;
    if (cap_data.size() !== 2) $display("FAIL int8_count: got %0d want 2", cap_data.size());
    else pass_cnt++;
    total_cnt++;
    if ({cap_data[0], cap_data[1]} !== 32'h7F12_0080)
      $display("FAIL int8_words: got %h %h want 7f12 0080", cap_data[0], cap_data[1]);
    else pass_cnt++;
    total_cnt++;
    if ({cap_last[0], cap_last[1], cap_prec[0], cap_prec[1]} !== 6'b01_01_01)
      $display("FAIL int8_last_prec: got %b want 010101", {cap_last[0], cap_last[1], cap_prec[0], cap_prec[1]});
    else pass_cnt++;
    total_cnt++;
    if (cap_done !== 1) $display("FAIL int8_done: got %0d want 1", cap_done);
    else pass_cnt++;
  endtask

  task automatic test_fp16();
    logic [15:0] elems [4];
    elems = '{16'h1234, 16'h7FF0, 16'h8000, 16'h0000};
    sel = 1'b0;
    vec[0] = {64'h0, 16'h0000, 16'h8000, 16'h7FF0, 16'h1234};
    for (int i = 0; i < 2; i++) begin
      logic [3:0] code;
      code = (i == 0) ? 4'd2 : 4'd9;
      run({8'h00, code}, 1, 0, 1'b0, 4'hF);
      total_cnt++;
      if (cap_data.size() !== 4) $display("FAIL fp16_count code %0d: got %0d want 4", code, cap_data.size());
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
        total_cnt++;
        if (cap_data[k] !== elems[k] || cap_prec[k] !== 2'd2 || cap_last[k] !== (k == 3))
          $display("FAIL fp16_word%0d code %0d: got %h/%0d/%b want %h/2/%b",
                   k, code, cap_data[k], cap_prec[k], cap_last[k], elems[k], (k == 3));
        else pass_cnt++;
      end
`ifdef TOKQ_STATS_EN
      total_cnt++;
      if ({a_s4, a_s8, a_s16} !== 3'b001) $display("FAIL fp16_stats: got %b want 001", {a_s4, a_s8, a_s16});
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] elems [4];
    elems = '{16'h1234, 16'h7FF0, 16'h8000, 16'h0000};
    sel = 1'b0;
    vec[0] = {64'h0, 16'h0000, 16'h8000, 16'h7FF0, 16'h1234};
    run(12'h002, 1, 0, 1'b0, 4'b1001);
    total_cnt++;
    if (cap_data.size() !== 4) $display("FAIL bp_count: got %0d want 4", cap_data.size());
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (cap_data[k] !== elems[k]) $display("FAIL bp_word%0d: got %h want %h", k, cap_data[k], elems[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_viol !== 0 || rdy_viol !== 0)
      $display("FAIL bp_hold: stall changes %0d tok_ready in emit %0d want 0 0", stall_viol, rdy_viol);
    else pass_cnt++;
    total_cnt++;
    if (cap_done !== 1) $display("FAIL bp_done: got %0d want 1", cap_done);
    else pass_cnt++;
  endtask

  task automatic load_multi_vectors();
    vec[0] = {16'hF7FF, 16'h07FF, 16'hF800, 16'h0800, 16'h0000, 16'h8000, 16'h7FF0, 16'h1234};
    vec[1] = {16'h0100, 16'h8000, 16'h7FF0, 16'h1234, 16'hFF7F, 16'hFF80, 16'h007F, 16'h0080};
    vec[2] = {16'h7FFF, 16'h8000, 16'hBEEF, 16'hDEAD, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
  endtask

  task automatic test_multi_token();
    logic [15:0] exp_w [14];
    logic [1:0]  exp_p [14];
    exp_w = '{16'h0871, 16'hF001, 16'h0001, 16'hFF00, 16'h7F12, 16'h0180, 16'h0000,
              16'h1111, 16'h2222, 16'h3333, 16'hDEAD, 16'hBEEF, 16'h8000, 16'h7FFF};
    exp_p = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    sel = 1'b1;
    load_multi_vectors();
    run(12'h210, 3, 3, 1'b1, 4'hF);
    total_cnt++;
    if (cap_wpt.size() !== 3 || cap_wpt[0] !== 2 || cap_wpt[1] !== 4 || cap_wpt[2] !== 8)
      $display("FAIL multi_wpt: got n=%0d %0d %0d %0d want 3 2 4 8",
               cap_wpt.size(), cap_wpt[0], cap_wpt[1], cap_wpt[2]);
    else pass_cnt++;
    for (int k = 0; k < 14; k++) begin
      total_cnt++;
      if (cap_data[k] !== exp_w[k] || cap_prec[k] !== exp_p[k])
        $display("FAIL multi_word%0d: got %h/%0d want %h/%0d", k, cap_data[k], cap_prec[k], exp_w[k], exp_p[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cap_done !== 1 || lat_viol !== 0 || feed_timeout || rdy_viol !== 0)
      $display("FAIL multi_done: done %0d lat %0d to %0d rdy %0d want 1 0 0 0",
               cap_done, lat_viol, feed_timeout, rdy_viol);
    else pass_cnt++;
`ifdef TOKQ_STATS_EN
    total_cnt++;
    if ({b_s4, b_s8, b_s16} !== 6'b01_01_01)
      $display("FAIL multi_stats: got %b want 010101", {b_s4, b_s8, b_s16});
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_run();
    int w;
    sel = 1'b1;
    load_multi_vectors();
    prec_vec     = 12'h210;
    lat_viol     = 0;
    feed_timeout = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      feed(2, 0, 1'b0);
      begin
        out_ready = 1'b1;
        w = 0;
        while (!(o_valid && o_prec == 2'd1) && w < 100) begin
          @(posedge clk); #1;
          w++;
        end
        total_cnt++;
        if (w >= 100) $display("FAIL rst_wait_token1: no int8 word within %0d cycles", w);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
      end
    join
    total_cnt++;
    if ({o_done, o_tok_ready, o_valid} !== 3'b000)
      $display("FAIL rst_mid_ctrl: got %b want 000", {o_done, o_tok_ready, o_valid});
    else pass_cnt++;
    total_cnt++;
    if ({o_prec, o_last, o_data} !== 19'h0)
      $display("FAIL rst_mid_data: got %h want 0", {o_prec, o_last, o_data});
    else pass_cnt++;
`ifdef TOKQ_STATS_EN
    total_cnt++;
    if ({b_s4, b_s8, b_s16} !== 6'b0)
      $display("FAIL rst_mid_stats: got %b want 000000", {b_s4, b_s8, b_s16});
    else pass_cnt++;
`endif
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(12'h210, 3, 0, 1'b0, 4'hF);
    total_cnt++;
    if (cap_data.size() !== 14 || cap_data[0] !== 16'h0871 || cap_data[1] !== 16'hF001)
      $display("FAIL rst_restart: got n=%0d %h %h want 14 0871 f001", cap_data.size(), cap_data[0], cap_data[1]);
    else pass_cnt++;
    total_cnt++;
    if (cap_done !== 1) $display("FAIL rst_restart_done: got %0d want 1", cap_done);
    else pass_cnt++;
  endtask

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    start     = 1'b0;
    prec_vec  = '0;
    tok_valid = 1'b0;
    tok_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_int4();
    test_int8();
    test_fp16();
    test_backpressure();
    test_multi_token();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
